// File: rtl/int_issue_queue_pkg.sv
// rtl/int_issue_queue_pkg.sv - shared core types for the integer issue queue
package int_issue_queue_pkg;

  localparam int IPR_IDX_W    = 7;
  localparam int IROB_IDX_W   = 6;
  localparam int IQ_NUMSRCS   = 2;
  localparam int IQ_PAYLOAD_W = 64;

  typedef logic [IPR_IDX_W-1:0]  iprIdx_t;
  typedef logic [IROB_IDX_W-1:0] irobIdx_t;

  typedef struct packed {
    irobIdx_t                     rob_idx;
    iprIdx_t                      dst_ipr_idx;
    iprIdx_t [IQ_NUMSRCS-1:0]     src_ipr_idx;
    logic [IQ_NUMSRCS-1:0]        src_rdy;
    logic [IQ_PAYLOAD_W-1:0]      payload;
  } iqEntry_t;

  // Index width that stays at least one bit for single-element ranges
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_iq_age_select.sv
// rtl/int_iq_age_select.sv - age matrix and per-port oldest-ready selection
module int_iq_age_select
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ENQ_NUM = 4,
  parameter int DEQ_NUM = 3,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int PORT_W = idx_w(DEQ_NUM),
  localparam int ENQ_W  = idx_w(ENQ_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [DEPTH-1:0]               valid,
  input  logic [DEPTH-1:0]               req,
  input  logic [DEPTH-1:0][PORT_W-1:0]   port,
  input  logic [DEPTH-1:0]               new_vld,
  input  logic [DEPTH-1:0][ENQ_W-1:0]    new_enq_port,
  output logic [DEQ_NUM-1:0]             sel_vld,
  output logic [DEQ_NUM-1:0][IDX_W-1:0]  sel_idx
);

  // older_q[i][j] set means entry i is older than entry j
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] col [DEPTH];
  logic [DEQ_NUM-1:0][DEPTH-1:0] cand;

  // Rewrite row and column of each newly allocated entry; existing entries stay older
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (new_vld[j]) begin
            older_q[i][j] <= new_vld[i] ? (new_enq_port[i] < new_enq_port[j]) : valid[i];
          end else if (new_vld[i]) begin
            older_q[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // Column view: col[i][j] set when entry j is older than entry i
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      col[i] = '0;
      for (int j = 0; j < DEPTH; j++) col[i][j] = older_q[j][i];
    end
  end

  // Per port, pick the ready candidate that no other candidate is older than
  always_comb begin
    sel_vld = '0;
    sel_idx = '0;
    cand    = '0;
    for (int p = 0; p < DEQ_NUM; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        cand[p][i] = req[i] && (port[i] == PORT_W'(p));
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (cand[p][i] && !(|(cand[p] & col[i]))) begin
          sel_vld[p] = 1'b1;
          sel_idx[p] = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - integer issue queue top; INT_IQ_ENQ_BYPASS_WAKE_EN enables enqueue-cycle wakeup
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ENQ_NUM   = 4,
  parameter int DEQ_NUM   = 3,
  parameter int WAKE_NUM  = 6,
  parameter int NUMSRCS   = IQ_NUMSRCS,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = IDX_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_squash_vld,
  input  logic [ENQ_NUM-1:0]            i_enq_vld,
  output logic                          o_enq_rdy,
  input  iqEntry_t [ENQ_NUM-1:0]        i_enq_info,
  input  logic [WAKE_NUM-1:0]           i_wake_vld,
  input  iprIdx_t [WAKE_NUM-1:0]        i_wake_iprIdx,
  output logic [DEQ_NUM-1:0]            o_iss_vld,
  input  logic [DEQ_NUM-1:0]            i_iss_rdy,
  output iqEntry_t [DEQ_NUM-1:0]        o_iss_info,
  output logic [CNT_W-1:0]              o_free_cnt
);

  localparam int PORT_W = idx_w(DEQ_NUM);
  localparam int ENQ_W  = idx_w(ENQ_NUM);

  // The entry struct has fixed widths; the module parameters must agree with it
  if (NUMSRCS != IQ_NUMSRCS || PAYLOAD_W != IQ_PAYLOAD_W) begin : g_cfg_check
    $error("int_issue_queue: NUMSRCS/PAYLOAD_W must match iqEntry_t");
  end

  logic [DEPTH-1:0]               valid_q;
  iqEntry_t                       entry_q [DEPTH];
  logic [DEPTH-1:0][PORT_W-1:0]   port_q;
  logic [PORT_W-1:0]              rr_ptr;
  logic [PORT_W-1:0]              rr_nxt;

  logic                           enq_fire;
  logic [DEPTH-1:0]               new_vld;
  logic [DEPTH-1:0][ENQ_W-1:0]    new_enq_port;
  logic [DEPTH-1:0][PORT_W-1:0]   new_iss_port;
  iqEntry_t                       enq_entry [DEPTH];
  logic [DEPTH-1:0][NUMSRCS-1:0]  stored_wake;
  logic [DEPTH-1:0]               req;
  logic [DEPTH-1:0]               iss_free;
  logic [DEQ_NUM-1:0]             sel_vld;
  logic [DEQ_NUM-1:0][IDX_W-1:0]  sel_idx;

  function automatic logic wake_hit(input iprIdx_t tag, input logic [WAKE_NUM-1:0] vld,
                                    input iprIdx_t [WAKE_NUM-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKE_NUM; w++) hit = hit | (vld[w] && (idx[w] == tag));
    return hit;
  endfunction

  // Free count is a popcount of empty slots; same-edge frees show up next cycle
  always_comb begin
    o_free_cnt = '0;
    for (int i = 0; i < DEPTH; i++) o_free_cnt = o_free_cnt + {{IDX_W{1'b0}}, ~valid_q[i]};
  end

  assign o_enq_rdy = (o_free_cnt >= CNT_W'(ENQ_NUM));
  assign enq_fire  = o_enq_rdy && !i_squash_vld;

  // Map the k-th valid enqueue port onto the k-th free slot and a round-robin issue port
  always_comb begin
    int fr;
    int rank;
    int fr_rank [DEPTH];
    new_vld      = '0;
    new_enq_port = '0;
    new_iss_port = '0;
    fr           = 0;
    rank         = 0;
    for (int i = 0; i < DEPTH; i++) begin
      fr_rank[i] = fr;
      if (!valid_q[i]) fr = fr + 1;
    end
    for (int k = 0; k < ENQ_NUM; k++) begin
      if (enq_fire && i_enq_vld[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!valid_q[i] && fr_rank[i] == rank) begin
            new_vld[i]      = 1'b1;
            new_enq_port[i] = ENQ_W'(k);
            new_iss_port[i] = PORT_W'((int'(rr_ptr) + rank) % DEQ_NUM);
          end
        end
        rank = rank + 1;
      end
    end
    rr_nxt = PORT_W'((int'(rr_ptr) + rank) % DEQ_NUM);
  end

  // Wakeup match against stored sources, and the incoming entry image per slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < NUMSRCS; s++) begin
        stored_wake[i][s] = wake_hit(entry_q[i].src_ipr_idx[s], i_wake_vld, i_wake_iprIdx);
      end
      enq_entry[i] = i_enq_info[new_enq_port[i]];
`ifdef INT_IQ_ENQ_BYPASS_WAKE_EN
      for (int s = 0; s < NUMSRCS; s++) begin
        if (wake_hit(enq_entry[i].src_ipr_idx[s], i_wake_vld, i_wake_iprIdx)) begin
          enq_entry[i].src_rdy[s] = 1'b1;
        end
      end
`endif
      req[i] = valid_q[i] && (&entry_q[i].src_rdy);
    end
  end

  // Slots whose presented entry is accepted this cycle
  always_comb begin
    iss_free = '0;
    for (int p = 0; p < DEQ_NUM; p++) begin
      if (sel_vld[p] && i_iss_rdy[p]) iss_free[sel_idx[p]] = 1'b1;
    end
  end

  // Valid bits and round-robin pointer; squash and reset wipe both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rr_ptr  <= '0;
    end else if (i_squash_vld) begin
      valid_q <= '0;
      rr_ptr  <= '0;
    end else begin
      valid_q <= (valid_q & ~iss_free) | new_vld;
      rr_ptr  <= rr_nxt;
    end
  end

  // Entry payload storage; only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (new_vld[i]) begin
        entry_q[i] <= enq_entry[i];
        port_q[i]  <= new_iss_port[i];
      end else begin
        for (int s = 0; s < NUMSRCS; s++) begin
          if (stored_wake[i][s]) entry_q[i].src_rdy[s] <= 1'b1;
        end
      end
    end
  end

  int_iq_age_select #(
    .DEPTH   (DEPTH),
    .ENQ_NUM (ENQ_NUM),
    .DEQ_NUM (DEQ_NUM)
  ) u_age_select (
    .clk          (clk),
    .rst          (rst),
    .clear        (i_squash_vld),
    .valid        (valid_q),
    .req          (req),
    .port         (port_q),
    .new_vld      (new_vld),
    .new_enq_port (new_enq_port),
    .sel_vld      (sel_vld),
    .sel_idx      (sel_idx)
  );

  assign o_iss_vld = sel_vld;

  // Drive issue data from the selected slot of each port
  always_comb begin
    for (int p = 0; p < DEQ_NUM; p++) o_iss_info[p] = entry_q[sel_idx[p]];
  end

endmodule
